// File: rtl/somador_pkg.sv
// Constants shared by the 4-bit adder datapath: FSM state encoding and operand width.
package somador_pkg;

  localparam int OPERANDO_W = 4;

  typedef enum logic [1:0] {
    ESPERA_X = 2'b00,
    ESPERA_Y = 2'b01,
    PRONTO   = 2'b10
  } estado_t;

endpackage

// File: rtl/filtro_botao.sv
// Pushbutton conditioner: two-flop synchronizer, debounce counter and press pulse.
module filtro_botao #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic KEY_n,
  output logic aperto
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMITE = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             nivel_q, nivel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             aperto_q, aperto_d;

  // NOTE: every signal gets a default first so no path through the block leaves one unassigned (no latch).
  always_comb begin
    nivel_d  = nivel_q;
    cnt_d    = cnt_q;
    aperto_d = 1'b0;
    if (sync_q[1] == nivel_q) begin
      cnt_d = '0;
    end else if (cnt_q == LIMITE) begin
      // Accepting the new level on this edge makes the filter span exactly DEBOUNCE_CYCLES edges.
      nivel_d  = sync_q[1];
      cnt_d    = '0;
      aperto_d = nivel_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: non-blocking assignments keep every flop sampling the pre-edge values of the others.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync_q   <= 2'b11;
      nivel_q  <= 1'b1;
      cnt_q    <= '0;
      aperto_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], KEY_n};
      nivel_q  <= nivel_d;
      cnt_q    <= cnt_d;
      aperto_q <= aperto_d;
    end
  end

  assign aperto = aperto_q;

endmodule

// File: rtl/captura_operandos.sv
// Operand entry stage: one debounced press per step latches x, then y/carry-in, then clears.
module captura_operandos
  import somador_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [OPERANDO_W-1:0] SW,
  input  logic                  SW_cin,
  input  logic                  KEY_n,
  output logic [OPERANDO_W-1:0] x,
  output logic [OPERANDO_W-1:0] y,
  output logic                  te0,
  output logic                  pronto,
  output logic [2:0]            LEDG
);

  logic aperto;

  filtro_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_filtro (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .KEY_n   (KEY_n),
    .aperto  (aperto)
  );

  estado_t               estado_q, estado_d;
  logic [OPERANDO_W-1:0] x_q, x_d, y_q, y_d;
  logic                  te0_q, te0_d;

  always_comb begin
    estado_d = estado_q;
    x_d      = x_q;
    y_d      = y_q;
    te0_d    = te0_q;
    case (estado_q)
      ESPERA_X: if (aperto) begin
        x_d      = SW;
        estado_d = ESPERA_Y;
      end
      ESPERA_Y: if (aperto) begin
        y_d      = SW;
        te0_d    = SW_cin;
        estado_d = PRONTO;
      end
      PRONTO: if (aperto) begin
        x_d      = '0;
        y_d      = '0;
        te0_d    = 1'b0;
        estado_d = ESPERA_X;
      end
      default: begin
        x_d      = '0;
        y_d      = '0;
        te0_d    = 1'b0;
        estado_d = ESPERA_X;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      estado_q <= ESPERA_X;
      x_q      <= '0;
      y_q      <= '0;
      te0_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      x_q      <= x_d;
      y_q      <= y_d;
      te0_q    <= te0_d;
    end
  end

  // Indicators decode straight from the state register, so they cannot glitch.
  assign x      = x_q;
  assign y      = y_q;
  assign te0    = te0_q;
  assign pronto = (estado_q == PRONTO);
  assign LEDG   = {estado_q == PRONTO, estado_q == ESPERA_Y, estado_q == ESPERA_X};

endmodule

// File: doc/captura_operandos.md
# captura_operandos

Operand entry stage for the 4-bit adder datapath on the DE2 board. The block debounces a single pushbutton and steps through a three-state sequence: latch operand x from the switches, latch operand y and the carry-in, then hold the result. It drives `x`, `y` and `te0` of the downstream adder with registered, stable values, so the adder and its 7-segment decoders never see raw switch movement. One capture happens per button press.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 50000 — consecutive stable cycles required to accept a button level change (1 ms at 50 MHz).

Ports:
- `CLOCK_50`  in  1 — single clock; all state on rising edge.
- `reset`  in  1 — synchronous, active-high.
- `SW`  in  4 — operand value from the switches, unsigned.
- `SW_cin`  in  1 — carry-in switch.
- `KEY_n`  in  1 — raw pushbutton, active-low, asynchronous to the clock, bouncy.
- `x`  out  4 — operand A to the adder, registered.
- `y`  out  4 — operand B to the adder, registered.
- `te0`  out  1 — carry-in to the adder, registered.
- `pronto`  out  1 — high while both operands are held (state PRONTO).
- `LEDG`  out  3 — one-hot state indicator: bit0 ESPERA_X, bit1 ESPERA_Y, bit2 PRONTO.

## Operation

- **Input synchronizer:** two flip-flops on `KEY_n`. Reset value is 1 (released).
- **Debounce filter:**
  - Holds a debounced level `nivel` (reset 1) and a counter (reset 0).
  - Each cycle where the synchronized level differs from `nivel`, the counter increments.
  - Any cycle where they are equal clears the counter.
  - When the counter reaches `DEBOUNCE_CYCLES`, `nivel` takes the synchronized value and the counter clears.
  - The counter is sized for `DEBOUNCE_CYCLES` and never wraps.
- **Press pulse:** `aperto` is high for exactly one cycle when `nivel` goes 1→0. A release (0→1) produces no pulse.
- **FSM** (moves only on `aperto`):
  - ESPERA_X: on `aperto`, `x` ← `SW`. Go to ESPERA_Y.
  - ESPERA_Y: on `aperto`, `y` ← `SW` and `te0` ← `SW_cin`. Go to PRONTO.
  - PRONTO: on `aperto`, `x`, `y` and `te0` ← 0. Go to ESPERA_X.
  - Unused encoding 2'b11: go to ESPERA_X on the next edge, with outputs cleared.
- **Switch sampling:** `SW` and `SW_cin` are sampled only on the `aperto` cycle. Switch movement at any other time has no effect.
- **Reset values:** `x`=0, `y`=0, `te0`=0, `pronto`=0, `LEDG`=3'b001, state ESPERA_X, sync FFs=1, `nivel`=1, counter=0.
- **Reset mid-operation:** reset wins over `aperto` in the same cycle. All state returns to the reset values on that edge.
- **Button held through reset:** after reset releases, a still-held button is treated as a new press. It produces one `aperto` after the normal debounce latency.

## Timing

- **Press latency:** take edge 1 as the first rising edge at which `KEY_n` is sampled low, with the button then held clean. The `x`/`y`/`te0` update and the state change both occur on edge `DEBOUNCE_CYCLES`+3 (2 sync edges + `DEBOUNCE_CYCLES` filter edges + 1 register edge).
- **Glitches:** a low glitch shorter than `DEBOUNCE_CYCLES` cycles after synchronization produces no pulse and leaves the counter at 0.
- **Output stability:**
  - `pronto` and `LEDG` are decoded from the state register and are glitch-free.
  - `pronto` rises on the same edge that `y` is loaded.
  - `x`, `y` and `te0` change only on state-transition edges.
- **Throughput:** at most one capture per debounced press.

## Structure

- **Shared package `somador_pkg`:** state encoding constants ESPERA_X=2'b00, ESPERA_Y=2'b01, PRONTO=2'b10, and the operand width constant (4). These are reused by the adder top and the display logic.
- **Sub-module `filtro_botao`:** the synchronizer, debounce counter and press-pulse generator. Ports: `CLOCK_50`, `reset`, `KEY_n` → `aperto`; parameter `DEBOUNCE_CYCLES`.
- **Top level:** `captura_operandos` instantiates `filtro_botao` and holds the FSM and the operand registers.

## Test plan

All scenarios run with `DEBOUNCE_CYCLES`=4.

1. **Reset:** assert `reset` for 2 cycles with `SW`=4'hF → `x`=0, `y`=0, `te0`=0, `pronto`=0, `LEDG`=3'b001.
2. **Bounce rejection:** `KEY_n` low for 3 cycles, high 2, low 2, then high → no state change, `x` stays 0, `LEDG`=3'b001.
3. **Full sequence:**
   - `SW`=9, press held 20 cycles → `x`=9 on edge 7 after the first low sample, `LEDG`=3'b010.
   - Then `SW`=7, `SW_cin`=1, press → `y`=7, `te0`=1, `pronto`=1.
   - Adder HEX1/HEX0 then show 1 and 7.
4. **Long hold and release:** `KEY_n` held low 100 cycles, then released → exactly one capture. Change `SW` during the hold → the captured value is the one present on the `aperto` cycle.
5. **Clear from PRONTO:** a third press in PRONTO → `x`=`y`=`te0`=0 and `pronto`=0 on edge 7, `LEDG`=3'b001.
6. **Reset mid-operation:** assert `reset` in ESPERA_Y on the same cycle as `aperto` → the next edge gives `x`=0, state ESPERA_X, and `y` is not loaded.
